// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and grant encodings for the MIPS bus arbiter
package mips_bus_pkg;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    // State encoding doubles as the grant_id value, so GRANT_I/GRANT_D are the grant constants
    typedef enum logic [1:0] {
        IDLE    = GRANT_NONE,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_id_t;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// mips_bus_rr_pick: combinational two-way round-robin winner
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  client_id_t last,
    output arb_state_t pick
);

    // On a tie the client not served last wins; no request yields IDLE
    always_comb begin
        pick = (req_i && req_d) ? ((last == CLIENT_D) ? GRANT_I : GRANT_D) :
               req_i ? GRANT_I :
               req_d ? GRANT_D : IDLE;
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter sharing one Avalon master between instruction and data clients
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [31:0]       i_writedata,
    input  logic [3:0]        i_byteenable,
    output logic [31:0]       i_readdata,
    output logic              i_waitrequest,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic [31:0]       d_readdata,
    output logic              d_waitrequest,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic [1:0]        grant_id
);

    arb_state_t state, state_nxt, pick;
    client_id_t last, last_nxt;
    logic       req_i, req_d, req_g, done;

    mips_bus_rr_pick u_pick (
        .req_i (req_i),
        .req_d (req_d),
        .last  (last_nxt),
        .pick  (pick)
    );

    // State, last-served and registered grant_id; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= CLIENT_D;
            grant_id <= GRANT_NONE;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            grant_id <= state_nxt;
        end
    end

    // Next-state selection plus master/client muxing; read+write from a client counts as a write
    always_comb begin
        req_i         = i_read | i_write;
        req_d         = d_read | d_write;
        req_g         = (state == GRANT_I) ? req_i : (state == GRANT_D) ? req_d : 1'b0;
        done          = req_g & ~waitrequest;
        last_nxt      = done ? ((state == GRANT_D) ? CLIENT_D : CLIENT_I) : last;
        state_nxt     = ((state == IDLE) || done) ? pick : (req_g ? state : IDLE);
        address       = (state == GRANT_I) ? i_address : (state == GRANT_D) ? d_address : '0;
        read          = (state == GRANT_I) ? (i_read & ~i_write) :
                        (state == GRANT_D) ? (d_read & ~d_write) : 1'b0;
        write         = (state == GRANT_I) ? i_write : (state == GRANT_D) ? d_write : 1'b0;
        writedata     = (state == GRANT_I) ? i_writedata : (state == GRANT_D) ? d_writedata : '0;
        byteenable    = (state == GRANT_I) ? i_byteenable : (state == GRANT_D) ? d_byteenable : '0;
        i_waitrequest = (state == GRANT_I) ? waitrequest : 1'b1;
        d_waitrequest = (state == GRANT_D) ? waitrequest : 1'b1;
        i_readdata    = readdata;
        d_readdata    = readdata;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width on all ports.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have instruction client ports i_address (in, 32), i_read (in, 1), i_write (in, 1), i_writedata (in, 32), i_byteenable (in, 4), i_readdata (out, 32), i_waitrequest (out, 1).
REQ-005 SHALL have data client ports d_address, d_read, d_write, d_writedata, d_byteenable, d_readdata and d_waitrequest, with the same widths and directions as REQ-004.
REQ-006 SHALL have Avalon master ports address (out, 32), read (out, 1), write (out, 1), writedata (out, 32), byteenable (out, 4), waitrequest (in, 1) and readdata (in, 32).
REQ-007 SHALL have port grant_id, output, 2 bits: 00 = none, 01 = instruction client, 10 = data client.

Function
REQ-008 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-009 A client request SHALL be (x_read | x_write).
REQ-010 In IDLE with one request pending, the FSM SHALL move to that client's GRANT state on the next edge.
REQ-011 In IDLE with both requests pending, the client not served last SHALL win (round-robin); after reset, last-served SHALL be D, so I wins the first tie.
REQ-012 In IDLE, the master read, write and byteenable outputs SHALL be 0; address and writedata SHALL be 0.
REQ-013 In GRANT_x, the master outputs SHALL combinationally mirror client x's address, read, write, writedata and byteenable.
REQ-014 If a client asserts read and write together, it SHALL be treated as a write: master read = 0.
REQ-015 The non-granted client SHALL see x_waitrequest = 1 at all times.
REQ-016 The granted client SHALL see x_waitrequest = waitrequest.
REQ-017 An IDLE client with no request SHALL see x_waitrequest = 1.
REQ-018 i_readdata and d_readdata SHALL both equal readdata at all times; validity is qualified only by the client's own waitrequest.
REQ-019 Completion SHALL be defined as: in GRANT_x, client x request = 1 and waitrequest = 0. On completion, last-served SHALL be set to x.
REQ-020 On completion, the next state SHALL be chosen by the REQ-010/011 rules using the updated last-served value, so back-to-back transfers need no IDLE cycle.
REQ-021 On completion, the grant SHALL move to the other client if it is requesting; otherwise the FSM SHALL re-grant x if x still requests, else go to IDLE.
REQ-022 If the granted client drops its request before completion, the FSM SHALL return to IDLE next edge with last-served unchanged.
REQ-023 A grant SHALL never change while waitrequest = 1 and the granted request is held.
REQ-024 Latency from request assertion in IDLE to the master strobe SHALL be 1 cycle; with waitrequest = 0, a single transfer SHALL occupy 2 cycles.
REQ-025 grant_id SHALL be a registered copy of the state encoding.

Reset
REQ-026 On reset assertion, asynchronously: state = IDLE, last-served = D, grant_id = 00.
REQ-027 While reset is high, all master strobes SHALL be 0 and both client waitrequests SHALL be 1.
REQ-028 A reset asserted mid-transfer SHALL abandon the transfer; the client SHALL reissue it.
REQ-029 Outputs SHALL be valid from the first edge after reset deasserts.

Structure
REQ-030 Package mips_bus_pkg SHALL hold arb_state_t (IDLE/GRANT_I/GRANT_D), the client_id_t encoding and constants GRANT_NONE, GRANT_I and GRANT_D.
REQ-031 A single sub-module, mips_bus_rr_pick, SHALL be used: combinational 2-way round-robin winner from (req_i, req_d, last).
REQ-032 All remaining logic SHALL live in mips_bus_arbiter: one always_ff for state and last-served, one always_comb for next-state and muxing.

Verification
REQ-033 Single read: i_read = 1, i_address = 0x1000, waitrequest = 0 -> cycle 1 address = 0x1000, read = 1; i_waitrequest = 0 that cycle; grant_id = 01.
REQ-034 Tie: i_read and d_write (d_address = 0x2000, d_writedata = 0xDEADBEEF) asserted together after reset -> I served first, then D back-to-back with no IDLE cycle; write = 1 with writedata = 0xDEADBEEF on the D cycle.
REQ-035 Stall: d_read granted, waitrequest held 1 for 3 cycles while i_read is asserted -> grant_id stays 10 for 4 cycles, i_waitrequest = 1 throughout, then I is granted.
REQ-036 Starvation: both clients request continuously for 20 transfers -> grants strictly alternate I, D, I, D and neither client waits more than one transfer.
REQ-037 Abort and reset: d_write dropped while waitrequest = 1 -> IDLE next edge with no write completing; reset pulsed mid-grant -> strobes drop to 0 immediately (asynchronously) and grant_id = 00.
